// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI frame slave: FSM state encoding, counter sizing
// and SPI-mode-to-sample-edge selection.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Bit counter must reach FRAME_W+1 so an over-long frame stays distinguishable.
    function automatic int cnt_width(input int frame_w);
        return $clog2(frame_w + 2);
    endfunction

    // Sample on the rising SCLK edge when CPOL equals CPHA, otherwise on the falling edge.
    function automatic logic sample_on_rise(input int cpol, input int cpha);
        return (cpol == cpha);
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous SPI pin, with rise/fall detection
// on the synchronised level against one extra delay flop.
module spi_sync_edge #(
    parameter int STAGES   = 2,
    parameter bit IDLE_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              dly_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= {STAGES{IDLE_VAL}};
            dly_q  <= IDLE_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din};
            dly_q  <= sync_q[STAGES-1];
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = sync_q[STAGES-1] & ~dly_q;
    assign fall  = ~sync_q[STAGES-1] & dly_q;

endmodule

// File: rtl/spi_frame_slave.sv
// SPI slave frame engine: receives one FRAME_W-bit command per select window, shifts a
// preloaded response out on miso, and flags short/long frames and receive overruns.
//
//   state | meaning
//   IDLE  | waiting for select to fall; miso held low
//   SHIFT | frame in progress, bits sampled/shifted on sclk edges
//   DONE  | one cycle after select rises; frame committed or flagged
module spi_frame_slave
    import spi_pkg::*;
#(
    parameter int FRAME_W     = 136,
    parameter int OPC_W       = 8,
    parameter int CPOL        = 0,
    parameter int CPHA        = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sclk,
    input  logic               ssel,
    input  logic               mosi,
    output logic               miso,
    output logic [FRAME_W-1:0] rx_data,
    output logic [OPC_W-1:0]   rx_opcode,
    output logic               rx_valid,
    input  logic               rx_ready,
    input  logic [FRAME_W-1:0] tx_data,
    output logic               tx_busy,
    output logic               err_len,
    output logic               err_ovr
);

    localparam int               CNT_W       = cnt_width(FRAME_W);
    localparam logic [CNT_W-1:0] CNT_FULL    = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0] CNT_SAT     = CNT_W'(FRAME_W + 1);
    localparam bit               SAMPLE_RISE = sample_on_rise(CPOL, CPHA);

    logic sclk_lvl_unused, sclk_rise, sclk_fall;
    logic ssel_lvl, ssel_rise, ssel_fall;
    logic mosi_lvl, mosi_rise_unused, mosi_fall_unused;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .IDLE_VAL(1'(CPOL))) u_sync_sclk (
        .clk(clk), .reset(reset), .din(sclk),
        .level(sclk_lvl_unused), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .IDLE_VAL(1'b1)) u_sync_ssel (
        .clk(clk), .reset(reset), .din(ssel),
        .level(ssel_lvl), .rise(ssel_rise), .fall(ssel_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .IDLE_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .reset(reset), .din(mosi),
        .level(mosi_lvl), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );

    state_t             state_q, state_d;
    logic               start, finish;
    logic               fall_pend_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [FRAME_W-1:0] rx_sr_q;
    logic [FRAME_W-1:0] tx_sr_q;
    logic               sample_edge, shift_edge, shifting;

    assign sample_edge = SAMPLE_RISE ? sclk_rise : sclk_fall;
    assign shift_edge  = SAMPLE_RISE ? sclk_fall : sclk_rise;
    // Edges seen in the same cycle as the select release belong to no frame.
    assign shifting    = (state_q == SHIFT) && !ssel_lvl;

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        finish  = 1'b0;
        case (state_q)
            IDLE: begin
                if (ssel_fall || fall_pend_q) begin
                    state_d = SHIFT;
                    start   = 1'b1;
                end
            end
            SHIFT: begin
                if (ssel_rise) begin
                    state_d = DONE;
                    finish  = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            miso        <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            tx_busy     <= 1'b0;
            err_len     <= 1'b0;
            err_ovr     <= 1'b0;
            cnt_q       <= '0;
            rx_sr_q     <= '0;
            tx_sr_q     <= '0;
            fall_pend_q <= 1'b0;
        end else begin
            err_len <= 1'b0;
            err_ovr <= 1'b0;

            if (rx_valid && rx_ready) rx_valid <= 1'b0;

            if (state_q == DONE && ssel_fall) fall_pend_q <= 1'b1;
            else if (start)                   fall_pend_q <= 1'b0;

            if (state_q == IDLE && !start) miso <= 1'b0;

            if (start) begin
                tx_busy <= 1'b1;
                cnt_q   <= '0;
                if (CPHA == 0) begin
                    miso    <= tx_data[FRAME_W-1];
                    tx_sr_q <= {tx_data[FRAME_W-2:0], 1'b0};
                end else begin
                    miso    <= 1'b0;
                    tx_sr_q <= tx_data;
                end
            end

            if (shifting) begin
                if (sample_edge) begin
                    rx_sr_q <= {rx_sr_q[FRAME_W-2:0], mosi_lvl};
                    if (cnt_q != CNT_SAT) cnt_q <= cnt_q + 1'b1;
                end
                // In CPHA 0 the first bit is already on miso; a stray shift edge before
                // the first sample must not advance it.
                if (shift_edge && !(CPHA == 0 && cnt_q == '0)) begin
                    miso    <= tx_sr_q[FRAME_W-1];
                    tx_sr_q <= {tx_sr_q[FRAME_W-2:0], 1'b0};
                end
            end

            if (finish) tx_busy <= 1'b0;

            if (state_q == DONE) begin
                miso <= 1'b0;
                if (cnt_q == CNT_FULL) begin
                    if (rx_valid) begin
                        err_ovr <= 1'b1;
                    end else begin
                        rx_data  <= rx_sr_q;
                        rx_valid <= 1'b1;
                    end
                end else begin
                    err_len <= 1'b1;
                end
            end
        end
    end

    assign rx_opcode = rx_data[FRAME_W-1 -: OPC_W];

endmodule

// File: tb/tb_spi_frame_slave.sv
// Bench for spi_frame_slave: one instance per SPI mode sharing sclk/mosi, random frames
// checked against a frame-level reference model of receive, overrun and length errors.
module tb_spi_frame_slave;

    localparam int FW = 136;
    localparam int OW = 8;
    localparam int H  = 42;
    localparam int NM = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          mosi = 1'b0;
    logic          sck = 1'b0;
    logic [FW-1:0] tx_data = '0;
    logic [NM-1:0] ssel_v = '1;
    logic [NM-1:0] rx_ready_v = '0;
    logic [NM-1:0] sclk_v, miso_v, rx_valid_v, tx_busy_v, err_len_v, err_ovr_v;
    logic [FW-1:0] rx_data_v [NM];
    logic [OW-1:0] rx_opc_v  [NM];

    int vectors = 0;
    int miscompares = 0;

    int            len_cnt [NM] = '{default: 0};
    int            ovr_cnt [NM] = '{default: 0};
    logic [FW-1:0] exp_data  [NM];
    bit            exp_valid [NM];
    int            exp_len   [NM];
    int            exp_ovr   [NM];

    always #8 clk = ~clk;

    for (genvar g = 0; g < NM; g++) begin : g_dut
        assign sclk_v[g] = sck ^ 1'(g / 2);
        spi_frame_slave #(
            .FRAME_W(FW), .OPC_W(OW), .CPOL(g / 2), .CPHA(g % 2), .SYNC_STAGES(2)
        ) u_dut (
            .clk(clk), .reset(reset), .sclk(sclk_v[g]), .ssel(ssel_v[g]), .mosi(mosi),
            .miso(miso_v[g]), .rx_data(rx_data_v[g]), .rx_opcode(rx_opc_v[g]),
            .rx_valid(rx_valid_v[g]), .rx_ready(rx_ready_v[g]), .tx_data(tx_data),
            .tx_busy(tx_busy_v[g]), .err_len(err_len_v[g]), .err_ovr(err_ovr_v[g])
        );
    end

    always @(posedge clk) begin
        for (int i = 0; i < NM; i++) begin
            if (err_len_v[i]) len_cnt[i] <= len_cnt[i] + 1;
            if (err_ovr_v[i]) ovr_cnt[i] <= ovr_cnt[i] + 1;
        end
    end

    task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [FW-1:0] rand_frame();
        logic [159:0] t;
        t = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return t[FW-1:0];
    endfunction

    // Frame-level reference: a full frame is taken only if the previous one was consumed.
    task automatic model_frame(input int m, input logic [FW-1:0] fr, input int nbits);
        if (nbits == FW) begin
            if (exp_valid[m]) exp_ovr[m]++;
            else begin
                exp_data[m]  = fr;
                exp_valid[m] = 1'b1;
            end
        end else begin
            exp_len[m]++;
        end
    endtask

    task automatic check_inst(input int m, input string tag);
        chk($sformatf("%s_valid_m%0d", tag, m), FW'(rx_valid_v[m]), FW'(exp_valid[m]));
        chk($sformatf("%s_data_m%0d", tag, m), rx_data_v[m], exp_data[m]);
        chk($sformatf("%s_opc_m%0d", tag, m), FW'(rx_opc_v[m]), FW'(exp_data[m][FW-1 -: OW]));
        chk($sformatf("%s_errlen_m%0d", tag, m), FW'(len_cnt[m]), FW'(exp_len[m]));
        chk($sformatf("%s_errovr_m%0d", tag, m), FW'(ovr_cnt[m]), FW'(exp_ovr[m]));
        chk($sformatf("%s_busy_m%0d", tag, m), FW'(tx_busy_v[m]), FW'(0));
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int m = 0; m < NM; m++) begin
            chk($sformatf("%s_miso_m%0d", tag, m), FW'(miso_v[m]), FW'(0));
            chk($sformatf("%s_valid_m%0d", tag, m), FW'(rx_valid_v[m]), FW'(0));
            chk($sformatf("%s_data_m%0d", tag, m), rx_data_v[m], FW'(0));
            chk($sformatf("%s_busy_m%0d", tag, m), FW'(tx_busy_v[m]), FW'(0));
            chk($sformatf("%s_err_m%0d", tag, m), FW'({err_len_v[m], err_ovr_v[m]}), FW'(0));
        end
    endtask

    task automatic abort_with_reset(input int m);
        @(negedge clk);
        reset     = 1'b1;
        ssel_v[m] = 1'b1;
        mosi      = 1'b0;
        repeat (6) @(negedge clk);
        check_reset_outputs("abort_in_reset");
        reset = 1'b0;
        repeat (4) @(negedge clk);
        for (int k = 0; k < NM; k++) begin
            exp_data[k]  = '0;
            exp_valid[k] = 1'b0;
            check_inst(k, "abort_after");
        end
    endtask

    // Master side: CPHA 0 drives mosi before the leading edge, CPHA 1 on it. miso is
    // captured just before the next shift edge so the slave's sync latency is covered.
    task automatic send_frame(input int m, input logic [FW-1:0] fr, input int nbits,
                              input int rst_at, output logic [FW-1:0] misow,
                              output logic tail);
        logic b;
        misow = '0;
        tail  = 1'b0;
        ssel_v[m] = 1'b0;
        #(2*H);
        for (int i = 0; i < nbits; i++) begin
            b = (i < FW) ? fr[FW-1-i] : 1'($urandom);
            if (m % 2 == 0) begin
                mosi = b;
                #H; sck = 1'b1;
                #(H-1);
            end else begin
                sck = 1'b1; mosi = b;
                #H; sck = 1'b0;
                #(H-1);
            end
            if (i < FW) misow[FW-1-i] = miso_v[m];
            else        tail = tail | miso_v[m];
            if (i == 1) chk($sformatf("busy_mid_m%0d", m), FW'(tx_busy_v[m]), FW'(1));
            #1;
            if (m % 2 == 0) sck = 1'b0;
            if (i + 1 == rst_at) begin
                abort_with_reset(m);
                return;
            end
        end
        #H;
        ssel_v[m] = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic accept(input int m);
        @(negedge clk);
        chk($sformatf("acc_pre_m%0d", m), FW'(rx_valid_v[m]), FW'(exp_valid[m]));
        rx_ready_v[m] = 1'b1;
        @(posedge clk);
        #1;
        chk($sformatf("acc_clr_m%0d", m), FW'(rx_valid_v[m]), FW'(0));
        @(negedge clk);
        rx_ready_v[m] = 1'b0;
        exp_valid[m]  = 1'b0;
    endtask

    initial begin
        logic [FW-1:0] fr, fr2, mw;
        logic          tl;
        int            m, nb, r;

        for (int k = 0; k < NM; k++) begin
            exp_data[k] = '0; exp_valid[k] = 1'b0; exp_len[k] = 0; exp_ovr[k] = 0;
        end

        repeat (5) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < NM; k++) check_inst(k, "post_reset");

        // Mode 0 command {1, 10}
        tx_data = rand_frame();
        fr = {8'd1, 128'd10};
        send_frame(0, fr, FW, 0, mw, tl);
        model_frame(0, fr, FW);
        check_inst(0, "t1");
        chk("t1_opcode", FW'(rx_opc_v[0]), FW'(1));
        chk("t1_payload", FW'(rx_data_v[0][127:0]), FW'(10));
        chk("t1_miso", mw, tx_data);
        accept(0);

        // A5 response in every mode
        for (int k = 0; k < NM; k++) begin
            tx_data = {17{8'hA5}};
            fr = rand_frame();
            send_frame(k, fr, FW, 0, mw, tl);
            model_frame(k, fr, FW);
            check_inst(k, "t2");
            chk($sformatf("t2_miso_m%0d", k), mw, tx_data);
            accept(k);
        end

        // Short frame, then recovery
        fr = rand_frame();
        send_frame(0, fr, 100, 0, mw, tl);
        model_frame(0, fr, 100);
        check_inst(0, "t3_short");
        fr = {8'd2, 128'd128};
        send_frame(0, fr, FW, 0, mw, tl);
        model_frame(0, fr, FW);
        check_inst(0, "t3_next");
        accept(0);

        // Overrun: second frame dropped while first is still pending
        fr  = rand_frame();
        fr2 = rand_frame();
        send_frame(0, fr, FW, 0, mw, tl);
        model_frame(0, fr, FW);
        send_frame(0, fr2, FW, 0, mw, tl);
        model_frame(0, fr2, FW);
        check_inst(0, "t4_ovr");
        accept(0);
        check_inst(0, "t4_acc");

        // Reset mid-frame at bit 60, then a clean frame
        fr = rand_frame();
        send_frame(0, fr, FW, 60, mw, tl);
        fr = {8'd3, 128'd0};
        send_frame(0, fr, FW, 0, mw, tl);
        model_frame(0, fr, FW);
        check_inst(0, "t5");
        accept(0);

        // 137 clocks: length error, data kept, miso idle after the last bit
        tx_data = rand_frame();
        fr = rand_frame();
        send_frame(0, fr, FW + 1, 0, mw, tl);
        model_frame(0, fr, FW + 1);
        check_inst(0, "t6");
        chk("t6_miso", mw, tx_data);
        chk("t6_tail", FW'(tl), FW'(0));

        // Random frames across modes and lengths
        for (int it = 0; it < 24; it++) begin
            m = int'($urandom_range(0, NM - 1));
            r = int'($urandom_range(0, 7));
            if (r <= 4)      nb = FW;
            else if (r == 5) nb = FW - 1;
            else if (r == 6) nb = FW + 1;
            else             nb = int'($urandom_range(0, 20));
            tx_data = rand_frame();
            fr = rand_frame();
            send_frame(m, fr, nb, 0, mw, tl);
            model_frame(m, fr, nb);
            if (nb >= FW) chk($sformatf("rnd%0d_miso_m%0d", it, m), mw, tx_data);
            for (int k = 0; k < NM; k++) check_inst(k, $sformatf("rnd%0d", it));
            if (exp_valid[m] && ($urandom_range(0, 1) == 1)) accept(m);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
